ahb_slave_mem: RTL
==================

// Module: ahb_slave_mem
// PURPOSE
//  AHB-Lite slave (responder) backed by a word-organised on-chip RAM, completer side of the CPU load/store master path.
//  Decodes address-phase transfers, inserts configurable wait states, performs byte/half/word writes and word reads.
//  Flags illegal accesses with the two-cycle ERROR response. Sits behind the AHB decoder/mux, one per memory region.
// PARAMETERS
//  MEM_WORDS    1024  RAM depth in 32-bit words, power of two; byte space = 4*MEM_WORDS
//  WAIT_STATES  0     data-phase wait cycles per OKAY transfer, 0..7
// PORTS
//  HCLK       in   1   bus clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  hsel       in   1   slave select from decoder
//  haddr      in   32  byte address (offset within region; bits above log2(4*MEM_WORDS) must be 0)
//  htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1   1 write, 0 read
//  hsize      in   3   000 byte, 001 half, 010 word; others illegal
//  hburst     in   3   ignored (each beat handled as a single transfer)
//  hprot      in   4   ignored
//  hmastlock  in   1   ignored
//  hwdata     in   32  write data, valid in data phase
//  hreadyin   in   1   bus HREADY (previous data phase complete)
//  hreadyout  out  1   slave ready
//  hresp      out  1   0 OKAY, 1 ERROR
//  hrdata     out  32  read data, valid when hreadyout=1 in a read data phase
// BEHAVIOUR
//  Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0; RAM contents not reset, undefined.
//  Accept: hsel & htrans[1] & hreadyin at rising edge; latch addr, hwrite, hsize; IDLE/BUSY or !hsel -> no transfer, zero-wait OKAY.
//  Error check at accept: hsize>010, misaligned (half: addr[0]!=0; word: addr[1:0]!=0), or addr out of range -> ERR path.
//  FSM:
//   IDLE : hreadyout=1, hresp=0. Legal accept -> DATA (cnt=WAIT_STATES); illegal accept -> ERR1.
//   DATA : hreadyout = (cnt==0), hresp=0; cnt decrements each cycle while >0.
//          On completing cycle (cnt==0): write commits; then new legal accept -> DATA, illegal -> ERR1, else -> IDLE.
//   ERR1 : hreadyout=0, hresp=1 (1 cycle) -> ERR2.
//   ERR2 : hreadyout=1, hresp=1; accept in this cycle handled as from IDLE, else -> IDLE. No RAM write on error.
//  Write: byte lanes from latched addr[1:0], hsize (byte: 1 lane, half: lanes {1,0} or {3,2}, word: all 4).
//         hwdata sampled on completing data-phase edge only; unselected lanes untouched.
//  Read: RAM word read synchronously on the accept edge; hrdata = full 32-bit word (master extracts lanes).
//        With WAIT_STATES>0 hrdata stable from first data-phase cycle until completion.
//  hrdata holds its last value outside read data phases; write/error transfers do not change it.
//  Hazard: read accepted on the edge a write to the same word commits -> hrdata returns merged new data (forwarding), never stale.
//  Back-to-back: zero-wait pipelined transfers sustain one transfer per cycle; address phase overlaps previous data phase.
//  Reset mid-transfer: FSM -> IDLE immediately, pending write discarded, outputs to reset values.
//  Address wrap: none; offsets >= 4*MEM_WORDS are errors, not aliased.
// TESTING
//  1 Word write 0xDEADBEEF @0x10, then read @0x10, WAIT_STATES=0 -> OKAY both, no wait, hrdata=0xDEADBEEF in read data phase.
//  2 Word 0x11223344 @0x20, byte write 0xAA @0x22, half write 0x5566 @0x20, read -> 0x11AA5566.
//  3 Back-to-back write 0xCAFEF00D @0x40 then read @0x40 (NONSEQ each cycle) -> read returns 0xCAFEF00D, no stall.
//  4 WAIT_STATES=3, read @0x8 -> hreadyout low exactly 3 cycles then high with correct hrdata, hresp=0 throughout.
//  5 Word read @0x2 (misaligned), hsize=011, addr=4*MEM_WORDS -> each gives hreadyout 0/1 with hresp 1/1; RAM unchanged.
//  6 Assert rst_n=0 during a wait-state write -> hreadyout=1, hresp=0, hrdata=0; target word unchanged after reset.

Source files
------------

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if
//  AHB-Lite signal bundle between a master (or decoder/mux) and one
//  ahb_slave_mem responder.
//  Ports (signals):
//   hsel, haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hburst[2:0],
//   hprot[3:0], hmastlock, hwdata[31:0], hreadyin  : toward the slave
//   hreadyout, hresp, hrdata[31:0]                  : from the slave
//  hreadyin is the muxed bus HREADY; it is grouped on the master side
//  because whoever drives the bus (mux or testbench) also supplies it.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
    input  hwdata, hreadyin,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
    output hwdata, hreadyin,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem
//  AHB-Lite responder backed by a word-organised RAM. Byte/half/word
//  writes, full-word reads, configurable wait states on OKAY transfers,
//  two-cycle ERROR response for illegal size, misalignment or an offset
//  outside the region.
//  Ports:
//   HCLK   in  bus clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    ahb_slave_mem_if.slave (address/control/data in, hreadyout,
//          hresp, hrdata out)
//  Parameters:
//   MEM_WORDS   RAM depth in 32-bit words, power of two
//   WAIT_STATES data-phase wait cycles per OKAY transfer, 0..7
//
//  state | meaning
//  IDLE  | no data phase in progress, ready, OKAY
//  DATA  | data phase of a legal transfer, counting down wait states
//  ERR1  | first ERROR cycle, hreadyout low
//  ERR2  | second ERROR cycle, hreadyout high; may accept a new transfer
module ahb_slave_mem #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic           HCLK,
  input  logic           rst_n,
  ahb_slave_mem_if.slave bus
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int ADDR_W = IDX_W + 2;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         be_q;
  logic               write_q;
  logic [31:0]        hrdata_q;

  logic [31:0]        mem [MEM_WORDS];

  logic               acc_req;
  logic               can_acc;
  logic               take;
  logic               illegal;
  logic               commit;
  logic               hready_o;
  logic               hresp_o;
  logic [IDX_W-1:0]   acc_idx;
  logic [3:0]         acc_be;
  logic [31:0]        rd_word;
  logic [31:0]        rd_fwd;

  // Transfer request in the current address phase.
  assign acc_req = bus.hsel & bus.htrans[1] & bus.hreadyin;
  assign acc_idx = bus.haddr[ADDR_W-1:2];

  always_comb begin
    illegal = 1'b0;
    if (bus.hsize > 3'b010) illegal = 1'b1;
    if ((bus.hsize == 3'b001) && bus.haddr[0]) illegal = 1'b1;
    if ((bus.hsize == 3'b010) && (bus.haddr[1:0] != 2'b00)) illegal = 1'b1;
    // No aliasing: any bit above the region size makes the access an error.
    if (|bus.haddr[31:ADDR_W]) illegal = 1'b1;
  end

  always_comb begin
    case (bus.hsize[1:0])
      2'b00:   acc_be = 4'b0001 << bus.haddr[1:0];
      2'b01:   acc_be = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: acc_be = 4'b1111;
    endcase
  end

  // Write completes on the last data-phase edge; hwdata is only sampled here.
  assign commit = (state_q == DATA) && (cnt_q == 3'd0) && write_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    can_acc  = 1'b0;
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    case (state_q)
      IDLE: can_acc = 1'b1;
      DATA: begin
        hready_o = (cnt_q == 3'd0);
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               can_acc = 1'b1;
      end
      ERR1: begin
        hready_o = 1'b0;
        hresp_o  = 1'b1;
        state_d  = ERR2;
      end
      ERR2: begin
        hresp_o = 1'b1;
        can_acc = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    take = can_acc & acc_req;
    if (can_acc) begin
      if (take && !illegal) begin
        state_d = DATA;
        cnt_d   = WAIT_INIT;
      end else if (take) begin
        state_d = ERR1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge HCLK or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      be_q    <= 4'b0000;
      write_q <= 1'b0;
    end else if (take && !illegal) begin
      idx_q   <= acc_idx;
      be_q    <= acc_be;
      write_q <= bus.hwrite;
    end else if (commit) begin
      // Pending write retires even when no new transfer follows.
      write_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  // A read accepted on the edge a write to the same word commits would see
  // the old RAM contents, so merge the committing lanes in.
  assign rd_word = mem[acc_idx];

  always_comb begin
    rd_fwd = rd_word;
    if (commit && (idx_q == acc_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) rd_fwd[8*i +: 8] = bus.hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge rst_n) begin
    if (!rst_n) begin
      hrdata_q <= 32'h0;
    end else if (take && !illegal && !bus.hwrite) begin
      hrdata_q <= rd_fwd;
    end
  end

  assign bus.hreadyout = hready_o;
  assign bus.hresp     = hresp_o;
  assign bus.hrdata    = hrdata_q;

  // Bus fields this responder does not act on.
  logic unused_ok;
  assign unused_ok = ^{bus.htrans[0], bus.hburst, bus.hprot, bus.hmastlock};

endmodule
